mono_mode_ctrl: RTL and testbench

Frame-synchronous controller for the monochrome video mode selector (00 colour, 01 green, 10 amber, 11 black-and-white) that drives the top-level colour/luma mux. It collects mode change requests from three sources: CPU I/O port writes, a keyboard hotkey pulse, and a raw front-panel/joystick button. It debounces the button, arbitrates between the sources and holds the result as a pending mode. The pending mode is committed to the video path only at the start of vertical sync, so a change never takes effect mid-frame.

---
 rtl/video_pkg.sv | 34 +++
 rtl/btn_debounce.sv | 91 +++++++++
 rtl/mono_mode_ctrl.sv | 109 ++++++++++
 tb/tb_mono_mode_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video-mode definitions: mode encodings, default mode-register address
// and the button debounce state encoding.
package video_pkg;

  // Monochrome switcher mode encodings
  localparam logic [1:0] MODE_COLOUR = 2'b00;
  localparam logic [1:0] MODE_GREEN  = 2'b01;
  localparam logic [1:0] MODE_AMBER  = 2'b10;
  localparam logic [1:0] MODE_BW     = 2'b11;

  // Default I/O address of the mode register
  localparam logic [15:0] DEFAULT_PORT_ADDR = 16'h03C3;

  // Button debounce FSM states
  typedef enum logic [1:0] {
    DbIdle,
    DbPressWait,
    DbHeld,
    DbRelWait
  } db_state_e;

  // Next mode in the step cycle; black-and-white wraps back to colour
  function automatic logic [1:0] next_mode(input logic [1:0] cur);
    logic [1:0] nxt;
    case (cur)
      MODE_COLOUR: nxt = MODE_GREEN;
      MODE_GREEN:  nxt = MODE_AMBER;
      MODE_AMBER:  nxt = MODE_BW;
      default:     nxt = MODE_COLOUR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Panel button conditioner: 2-flop synchroniser, press/release debounce FSM
// and a single-cycle step pulse per accepted press.
module btn_debounce
  import video_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 571428
) (
  input  logic clk_vga,
  input  logic rst_n,
  input  logic btn_n,
  output logic step
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             btn_low;
  db_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             step_q;

  // Saturating increment so a stalled compare can never wrap the counter
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_ONE;
  endfunction

  // Synchronise the raw active-low button; reset to the released level
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  assign btn_low = ~sync2_q;

  // Debounce FSM; the counter is loaded with 1 because the sample that
  // triggers the load already counts as the first stable cycle
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DbIdle;
      cnt_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        DbIdle: begin
          if (btn_low) begin
            cnt_q   <= CNT_ONE;
            state_q <= DbPressWait;
          end
        end
        DbPressWait: begin
          if (!btn_low) begin
            state_q <= DbIdle;
          end else if (cnt_q == CNT_LAST) begin
            step_q  <= 1'b1;
            state_q <= DbHeld;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end
        DbHeld: begin
          if (!btn_low) begin
            cnt_q   <= CNT_ONE;
            state_q <= DbRelWait;
          end
        end
        DbRelWait: begin
          if (btn_low) begin
            state_q <= DbHeld;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= DbIdle;
          end else begin
            cnt_q <= sat_inc(cnt_q);
          end
        end
        default: state_q <= DbIdle;
      endcase
    end
  end

  assign step = step_q;

endmodule

// File: rtl/mono_mode_ctrl.sv
// Monochrome mode controller: arbitrates CPU writes, keyboard hotkey and panel
// button into a pending mode, committed to the video path at vsync start.
module mono_mode_ctrl
  import video_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 571428,
  parameter logic [15:0] PORT_ADDR       = DEFAULT_PORT_ADDR,
  parameter logic        VSYNC_ACTIVE    = 1'b0
) (
  input  logic        clk_vga,
  input  logic        rst_n,
  input  logic        io_we,
  input  logic [15:0] io_addr,
  input  logic [7:0]  io_din,
  output logic [7:0]  io_dout,
  input  logic        hotkey,
  input  logic        btn_n,
  input  logic        vga_vsync,
  output logic [1:0]  mode,
  output logic        mode_pending
);

  logic       btn_step;
  logic       step_req;
  logic       cpu_wr;
  logic       commit;

  logic       vs_meta_q;
  logic       vs_sync_q;
  logic       vs_prev_q;
  logic [1:0] prime_q;

  logic [1:0] pending_q, pending_d;
  logic [1:0] mode_q, mode_d;
  logic       lock_q, lock_d;
  logic       mode_pending_q;

  logic       unused_din;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_vga(clk_vga),
    .rst_n  (rst_n),
    .btn_n  (btn_n),
    .step   (btn_step)
  );

  // Vsync synchroniser and edge register. The edge register holds the active
  // level until the synchroniser has been refilled after reset, so a pulse
  // already in progress at reset release never produces a commit.
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      vs_meta_q <= ~VSYNC_ACTIVE;
      vs_sync_q <= ~VSYNC_ACTIVE;
      vs_prev_q <= VSYNC_ACTIVE;
      prime_q   <= 2'b00;
    end else begin
      vs_meta_q <= vga_vsync;
      vs_sync_q <= vs_meta_q;
      prime_q   <= {prime_q[0], 1'b1};
      vs_prev_q <= prime_q[1] ? vs_sync_q : VSYNC_ACTIVE;
    end
  end

  assign commit   = (vs_sync_q == VSYNC_ACTIVE) && (vs_prev_q != VSYNC_ACTIVE);
  assign cpu_wr   = io_we && (io_addr == PORT_ADDR);
  // Coincident hotkey and button step merge into one step
  assign step_req = hotkey | btn_step;

  // Arbitration: CPU write beats a step; commit samples the old pending value
  always_comb begin
    pending_d = pending_q;
    lock_d    = lock_q;
    mode_d    = mode_q;
    if (commit) begin
      mode_d = pending_q;
    end
    if (cpu_wr) begin
      pending_d = io_din[1:0];
      lock_d    = io_din[7];
    end else if (step_req && !lock_q) begin
      pending_d = next_mode(pending_q);
    end
  end

  // Mode registers and the registered pending flag
  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      pending_q      <= MODE_COLOUR;
      mode_q         <= MODE_COLOUR;
      lock_q         <= 1'b0;
      mode_pending_q <= 1'b0;
    end else begin
      pending_q      <= pending_d;
      mode_q         <= mode_d;
      lock_q         <= lock_d;
      mode_pending_q <= (pending_q != mode_q);
    end
  end

  // Readback is unqualified; the bus mux decodes the address
  assign io_dout      = {lock_q, 3'b000, pending_q, mode_q};
  assign mode         = mode_q;
  assign mode_pending = mode_pending_q;

  assign unused_din = ^io_din[6:2];

endmodule

// File: tb/tb_mono_mode_ctrl.sv
// Self-checking bench for mono_mode_ctrl: vector table, directed corner-case
// sequences and a randomized run against a frame-level reference model.
module tb_mono_mode_ctrl;

  localparam int unsigned DB = 16;
  localparam logic [15:0] PA = 16'h03C3;
  localparam logic        VA = 1'b0;

  logic        clk_vga = 1'b0;
  logic        rst_n = 1'b1;
  logic        io_we = 1'b0;
  logic [15:0] io_addr = 16'h0000;
  logic [7:0]  io_din = 8'h00;
  logic [7:0]  io_dout;
  logic        hotkey = 1'b0;
  logic        btn_n = 1'b1;
  logic        vga_vsync = ~VA;
  logic [1:0]  mode;
  logic        mode_pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        hk;
    logic [7:0]  dout;
  } vec_t;

  vec_t vecs[12];

  mono_mode_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .PORT_ADDR      (PA),
    .VSYNC_ACTIVE   (VA)
  ) dut (
    .clk_vga     (clk_vga),
    .rst_n       (rst_n),
    .io_we       (io_we),
    .io_addr     (io_addr),
    .io_din      (io_din),
    .io_dout     (io_dout),
    .hotkey      (hotkey),
    .btn_n       (btn_n),
    .vga_vsync   (vga_vsync),
    .mode        (mode),
    .mode_pending(mode_pending)
  );

  always #5 clk_vga = ~clk_vga;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_vga);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    io_we = 1'b0;
    hotkey = 1'b0;
    btn_n = 1'b1;
    vga_vsync = ~VA;
    rst_n = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    ticks(3);
  endtask

  task automatic cpu_write(input logic [7:0] d);
    io_we = 1'b1;
    io_addr = PA;
    io_din = d;
    tick();
    io_we = 1'b0;
  endtask

  task automatic hot();
    hotkey = 1'b1;
    tick();
    hotkey = 1'b0;
  endtask

  task automatic vsync_pulse();
    vga_vsync = VA;
    ticks(6);
    vga_vsync = ~VA;
    ticks(6);
  endtask

  // Reference model state for the randomized run
  int m_pend, m_mode, m_lock, m_flag;
  logic vs_hist[$];

  task automatic model_edge();
    int  p_old, md_old;
    bit  fire;
    p_old  = m_pend;
    md_old = m_mode;
    vs_hist.push_back(vga_vsync);
    if (vs_hist.size() > 8) void'(vs_hist.pop_front());
    // Mode follows pending three edges after vsync enters its active level
    fire = (vs_hist[vs_hist.size()-3] == VA) && (vs_hist[vs_hist.size()-4] != VA);
    m_flag = (p_old != md_old) ? 1 : 0;
    if (fire) m_mode = p_old;
    if (io_we && io_addr == PA) begin
      m_pend = int'(io_din[1:0]);
      m_lock = int'(io_din[7]);
    end else if (hotkey && m_lock == 0) begin
      m_pend = (m_pend + 1) % 4;
    end
  endtask

  initial begin
    int vs_left;

    vecs[0]  = '{1'b1, PA,        8'h02, 1'b0, 8'h08};
    vecs[1]  = '{1'b0, PA,        8'h00, 1'b1, 8'h0C};
    vecs[2]  = '{1'b0, PA,        8'h00, 1'b1, 8'h00};
    vecs[3]  = '{1'b0, PA,        8'h00, 1'b1, 8'h04};
    vecs[4]  = '{1'b1, 16'h03C2,  8'h03, 1'b0, 8'h04};
    vecs[5]  = '{1'b1, PA,        8'h81, 1'b0, 8'h84};
    vecs[6]  = '{1'b0, PA,        8'h00, 1'b1, 8'h84};
    vecs[7]  = '{1'b1, PA,        8'h83, 1'b0, 8'h8C};
    vecs[8]  = '{1'b1, PA,        8'h03, 1'b0, 8'h0C};
    vecs[9]  = '{1'b1, PA,        8'h01, 1'b1, 8'h04};
    vecs[10] = '{1'b0, 16'h0000,  8'h00, 1'b1, 8'h08};
    vecs[11] = '{1'b1, 16'h13C3,  8'h80, 1'b1, 8'h0C};

    // Reset state
    do_reset();
    check("reset_mode", {6'b0, mode}, 8'h00);
    check("reset_dout", io_dout, 8'h00);
    check("reset_mode_pending", {7'b0, mode_pending}, 8'h00);

    // Vector table: writes, hotkeys, lock, wrong address, collision
    foreach (vecs[i]) begin
      io_we = vecs[i].we;
      io_addr = vecs[i].addr;
      io_din = vecs[i].din;
      hotkey = vecs[i].hk;
      tick();
      io_we = 1'b0;
      hotkey = 1'b0;
      check($sformatf("vec%0d_dout", i), io_dout, vecs[i].dout);
      check($sformatf("vec%0d_mode", i), {6'b0, mode}, 8'h00);
    end

    // CPU write then commit at vsync
    do_reset();
    cpu_write(8'h02);
    check("wr_dout", io_dout, 8'h08);
    tick();
    check("wr_mode_pending", {7'b0, mode_pending}, 8'h01);
    vga_vsync = VA;
    ticks(2);
    check("commit_early", {6'b0, mode}, 8'h00);
    tick();
    check("commit_mode", {6'b0, mode}, 8'h02);
    tick();
    check("commit_mode_pending", {7'b0, mode_pending}, 8'h00);
    check("commit_dout", io_dout, 8'h0A);
    ticks(4);
    check("one_commit_per_pulse", {6'b0, mode}, 8'h02);
    vga_vsync = ~VA;
    ticks(4);

    // Hotkey wrap from pending=00
    cpu_write(8'h00);
    check("wrap_start", io_dout, 8'h02);
    hot(); check("wrap_01", io_dout, 8'h06);
    hot(); check("wrap_10", io_dout, 8'h0A);
    hot(); check("wrap_11", io_dout, 8'h0E);
    hot(); check("wrap_00", io_dout, 8'h02);
    vsync_pulse();
    check("wrap_commit", io_dout, 8'h00);

    // Debounce: short glitch gives no step
    btn_n = 1'b0;
    ticks(10);
    btn_n = 1'b1;
    ticks(40);
    check("glitch_no_step", io_dout, 8'h00);

    // 40-cycle press: step pulse at cycle 18, pending visible one cycle later
    btn_n = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == 18) check("press_before_step", io_dout, 8'h00);
      if (i == 19) check("press_step", io_dout, 8'h04);
    end
    check("press_single_step", io_dout, 8'h04);

    // Release bounce, then a second press
    btn_n = 1'b1; ticks(4);
    btn_n = 1'b0; ticks(2);
    btn_n = 1'b1; ticks(30);
    check("release_no_step", io_dout, 8'h04);
    btn_n = 1'b0; ticks(25);
    check("second_press", io_dout, 8'h08);
    btn_n = 1'b1; ticks(30);

    // Write landing on the commit edge: mode gets old pending
    vga_vsync = VA;
    ticks(2);
    io_we = 1'b1; io_addr = PA; io_din = 8'h01;
    tick();
    io_we = 1'b0;
    check("commit_collision_mode", {6'b0, mode}, 8'h02);
    check("commit_collision_dout", io_dout, 8'h06);
    vga_vsync = ~VA;
    ticks(5);
    check("collision_hold", {6'b0, mode}, 8'h02);
    vsync_pulse();
    check("collision_next_frame", io_dout, 8'h05);

    // Reset during PRESS_WAIT with mode=11
    cpu_write(8'h03);
    vsync_pulse();
    check("pre_reset_mode", {6'b0, mode}, 8'h03);
    btn_n = 1'b0;
    ticks(8);
    rst_n = 1'b0;
    ticks(2);
    btn_n = 1'b1;
    ticks(2);
    check("in_reset_dout", io_dout, 8'h00);
    check("in_reset_mode", {6'b0, mode}, 8'h00);
    rst_n = 1'b1;
    ticks(40);
    check("post_reset_dout", io_dout, 8'h00);
    check("post_reset_mode_pending", {7'b0, mode_pending}, 8'h00);

    // Randomized run against the reference model
    do_reset();
    m_pend = 0; m_mode = 0; m_lock = 0; m_flag = 0;
    vs_hist.delete();
    repeat (4) vs_hist.push_back(~VA);
    vs_left = 5;
    for (int c = 0; c < 1500; c++) begin
      io_we = ($urandom_range(0, 3) == 0);
      io_addr = ($urandom_range(0, 1) == 0) ? PA : 16'($urandom);
      io_din = 8'($urandom);
      hotkey = ($urandom_range(0, 4) == 0);
      if (vs_left == 0) begin
        vga_vsync = ~vga_vsync;
        vs_left = $urandom_range(3, 20);
      end
      vs_left--;
      @(posedge clk_vga);
      model_edge();
      #1;
      check("rand_dout", io_dout, 8'(m_lock * 128 + m_pend * 4 + m_mode));
      check("rand_mode", {6'b0, mode}, 8'(m_mode));
      check("rand_mode_pending", {7'b0, mode_pending}, 8'(m_flag));
    end
    io_we = 1'b0;
    hotkey = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
